// File: rtl/amp_if.sv
// Pin bundle between the PDM speaker driver side and the class-D amplifier control stage.
// audio_rdy is a level, not a handshake; state_dbg exposes the controller FSM state.
interface amp_if;
  logic       audio_rdy;
  logic       lft_pdm_in;
  logic       rght_pdm_in;
  logic       Flt_n;
  logic       sht_dwn;
  logic       lft_PDM;
  logic       lft_PDM_n;
  logic       rght_PDM;
  logic       rght_PDM_n;
  logic [2:0] fault_cnt;
  logic       lockout;
  logic [2:0] state_dbg;

  modport master (
    output audio_rdy, lft_pdm_in, rght_pdm_in, Flt_n,
    input  sht_dwn, lft_PDM, lft_PDM_n, rght_PDM, rght_PDM_n, fault_cnt, lockout, state_dbg
  );

  modport slave (
    input  audio_rdy, lft_pdm_in, rght_pdm_in, Flt_n,
    output sht_dwn, lft_PDM, lft_PDM_n, rght_PDM, rght_PDM_n, fault_cnt, lockout, state_dbg
  );
endinterface

// File: rtl/amp_ctrl.sv
// Class-D amplifier control: power-up sequencing with idle pattern, filtered fault
// detection, bounded retry and lockout. All outputs come straight from flops.
module amp_ctrl #(
  parameter int PWRUP_CYC = 250000,
  parameter int RETRY_CYC = 2500000,
  parameter int MAX_RETRY = 3,
  parameter int FLT_FILT  = 4
) (
  input logic  clk,
  input logic  rst_n,
  amp_if.slave bus
);

  localparam int MAX_CYC = (PWRUP_CYC > RETRY_CYC) ? PWRUP_CYC : RETRY_CYC;
  localparam int TMR_W   = $clog2(MAX_CYC + 1);
  localparam int FLT_W   = $clog2(FLT_FILT + 1);

  localparam logic [TMR_W-1:0] PWRUP_LAST = TMR_W'(PWRUP_CYC - 1);
  localparam logic [TMR_W-1:0] RETRY_LAST = TMR_W'(RETRY_CYC - 1);
  localparam logic [FLT_W-1:0] FLT_LAST   = FLT_W'(FLT_FILT - 1);
  localparam logic [FLT_W-1:0] FLT_TOP    = FLT_W'(FLT_FILT);
  localparam logic [2:0]       RETRY_TOP  = 3'(MAX_RETRY);

  typedef enum logic [2:0] {
    SHDN    = 3'd0,
    WARMUP  = 3'd1,
    RUN     = 3'd2,
    FAULT   = 3'd3,
    LOCKOUT = 3'd4
  } state_t;

  state_t           state;
  logic             flt_meta;
  logic             flt_s;
  logic [FLT_W-1:0] flt_cnt;
  logic [TMR_W-1:0] tmr;
  logic             sht_dwn_q;
  logic             lft_q, lft_n_q, rght_q, rght_n_q;
  logic [2:0]       fault_cnt_q;
  logic             lockout_q;
  logic             flt_det;
  logic             go_fault;

  // Detection fires on the edge that brings the filter count to FLT_FILT, so the
  // shutdown flop updates on that same edge.
  assign flt_det  = !flt_s && (flt_cnt >= FLT_LAST);
  assign go_fault = flt_det && ((state == WARMUP) || (state == RUN));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= SHDN;
      flt_meta    <= 1'b1;
      flt_s       <= 1'b1;
      flt_cnt     <= '0;
      tmr         <= '0;
      sht_dwn_q   <= 1'b1;
      lft_q       <= 1'b0;
      lft_n_q     <= 1'b0;
      rght_q      <= 1'b0;
      rght_n_q    <= 1'b0;
      fault_cnt_q <= 3'd0;
      lockout_q   <= 1'b0;
    end else begin
      flt_meta <= bus.Flt_n;
      flt_s    <= flt_meta;
      if (flt_s) begin
        flt_cnt <= '0;
      end else if (flt_cnt != FLT_TOP) begin
        flt_cnt <= flt_cnt + 1'b1;
      end

      if (go_fault) begin
        state     <= FAULT;
        tmr       <= '0;
        sht_dwn_q <= 1'b1;
        lft_q     <= 1'b0;
        lft_n_q   <= 1'b0;
        rght_q    <= 1'b0;
        rght_n_q  <= 1'b0;
        if (fault_cnt_q != RETRY_TOP) fault_cnt_q <= fault_cnt_q + 3'd1;
      end else begin
        case (state)
          SHDN: begin
            if (bus.audio_rdy) begin
              state     <= WARMUP;
              tmr       <= '0;
              sht_dwn_q <= 1'b0;
              lft_q     <= 1'b1;
              lft_n_q   <= 1'b0;
              rght_q    <= 1'b1;
              rght_n_q  <= 1'b0;
            end
          end
          WARMUP: begin
            if (tmr == PWRUP_LAST) begin
              state    <= RUN;
              tmr      <= '0;
              lft_q    <= bus.lft_pdm_in;
              lft_n_q  <= ~bus.lft_pdm_in;
              rght_q   <= bus.rght_pdm_in;
              rght_n_q <= ~bus.rght_pdm_in;
            end else begin
              tmr      <= tmr + 1'b1;
              lft_q    <= ~lft_q;
              lft_n_q  <= lft_q;
              rght_q   <= ~rght_q;
              rght_n_q <= rght_q;
            end
          end
          RUN: begin
            lft_q    <= bus.lft_pdm_in;
            lft_n_q  <= ~bus.lft_pdm_in;
            rght_q   <= bus.rght_pdm_in;
            rght_n_q <= ~bus.rght_pdm_in;
          end
          FAULT: begin
            // tmr == RETRY_LAST means RETRY_CYC cycles have been spent here including this one.
            if ((tmr == RETRY_LAST) && flt_s) begin
              tmr <= '0;
              if (fault_cnt_q == RETRY_TOP) begin
                state     <= LOCKOUT;
                lockout_q <= 1'b1;
              end else begin
                state     <= WARMUP;
                sht_dwn_q <= 1'b0;
                lft_q     <= 1'b1;
                lft_n_q   <= 1'b0;
                rght_q    <= 1'b1;
                rght_n_q  <= 1'b0;
              end
            end else if (tmr != RETRY_LAST) begin
              tmr <= tmr + 1'b1;
            end
          end
          LOCKOUT: begin
            state <= LOCKOUT;
          end
          default: begin
            state <= SHDN;
          end
        endcase
      end
    end
  end

  assign bus.sht_dwn    = sht_dwn_q;
  assign bus.lft_PDM    = lft_q;
  assign bus.lft_PDM_n  = lft_n_q;
  assign bus.rght_PDM   = rght_q;
  assign bus.rght_PDM_n = rght_n_q;
  assign bus.fault_cnt  = fault_cnt_q;
  assign bus.lockout    = lockout_q;
  assign bus.state_dbg  = state;

endmodule

// File: tb/tb_amp_ctrl.sv
// Bench for amp_ctrl: directed scenario sequence with randomized PDM data, every
// cycle compared against a time-since-event reference model of the amplifier stage.
module tb_amp_ctrl;
  localparam int PWRUP = 16;
  localparam int RETRY = 32;
  localparam int MAXR  = 2;
  localparam int FILT  = 4;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  amp_if bus();

  amp_ctrl #(
    .PWRUP_CYC(PWRUP),
    .RETRY_CYC(RETRY),
    .MAX_RETRY(MAXR),
    .FLT_FILT (FILT)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.slave)
  );

  int checks = 0;
  int errors = 0;
  logic [8:0] exp_q[$];

  // ---------------- reference model ----------------
  typedef enum {M_OFF, M_WARM, M_RUN, M_FLT, M_LOCK} mode_t;
  mode_t m_mode;
  int    m_dwell;
  int    m_faults;
  logic  m_l, m_r;
  logic  hist[$];   // raw Flt_n samples, newest first

  task automatic model_reset();
    m_mode   = M_OFF;
    m_dwell  = 0;
    m_faults = 0;
    m_l      = 1'b0;
    m_r      = 1'b0;
    hist.delete();
    for (int i = 0; i < FILT + 2; i++) hist.push_back(1'b1);
  endtask

  function automatic logic [8:0] m_outputs();
    logic p;
    logic lk;
    lk = (m_mode == M_LOCK);
    case (m_mode)
      M_WARM: begin
        p = (m_dwell % 2 == 0);
        return {1'b0, p, ~p, p, ~p, 3'(m_faults), lk};
      end
      M_RUN:  return {1'b0, m_l, ~m_l, m_r, ~m_r, 3'(m_faults), lk};
      default: return {1'b1, 4'b0000, 3'(m_faults), lk};
    endcase
  endfunction

  task automatic model_fault();
    m_mode  = M_FLT;
    m_dwell = 0;
    if (m_faults < MAXR) m_faults++;
  endtask

  // Flt_n takes two edges to reach flt_s; a fault is declared on the edge where
  // the last FILT synchronized samples (raw samples k-FILT-1 .. k-2) are all low.
  task automatic model_edge();
    logic det;
    logic fs;
    if (!rst_n) begin
      model_reset();
    end else begin
      hist.push_front(bus.Flt_n);
      void'(hist.pop_back());
      fs  = hist[2];
      det = 1'b1;
      for (int i = 2; i <= FILT + 1; i++) if (hist[i] !== 1'b0) det = 1'b0;
      case (m_mode)
        M_OFF: if (bus.audio_rdy) begin m_mode = M_WARM; m_dwell = 0; end
        M_WARM: begin
          if (det) model_fault();
          else begin
            m_dwell++;
            if (m_dwell == PWRUP) begin
              m_mode = M_RUN;
              m_l    = bus.lft_pdm_in;
              m_r    = bus.rght_pdm_in;
            end
          end
        end
        M_RUN: begin
          if (det) model_fault();
          else begin
            m_l = bus.lft_pdm_in;
            m_r = bus.rght_pdm_in;
          end
        end
        M_FLT: begin
          m_dwell++;
          if (m_dwell >= RETRY && fs) begin
            if (m_faults == MAXR) m_mode = M_LOCK;
            else begin m_mode = M_WARM; m_dwell = 0; end
          end
        end
        default: ;
      endcase
    end
    exp_q.push_back(m_outputs());
  endtask

  // ---------------- scoreboard ----------------
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [8:0] dut_vec();
    return {bus.sht_dwn, bus.lft_PDM, bus.lft_PDM_n, bus.rght_PDM, bus.rght_PDM_n,
            bus.fault_cnt, bus.lockout};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    chk("cycle", dut_vec(), exp_q.pop_front());
    chk("diff_both_high", {bus.lft_PDM & bus.lft_PDM_n, bus.rght_PDM & bus.rght_PDM_n}, 0);
  endtask

  task automatic tick_rand();
    bus.lft_pdm_in  = 1'($urandom_range(0, 1));
    bus.rght_pdm_in = 1'($urandom_range(0, 1));
    tick();
  endtask

  task automatic reset_async(input string tag);
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    exp_q.delete();
    chk(tag, dut_vec(), 9'b1_0000_000_0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  logic last_l;

  initial begin
    #100000;
    errors++;
    $display("FAIL watchdog expired at %0t", $time);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin
    bus.audio_rdy   = 1'b0;
    bus.lft_pdm_in  = 1'b0;
    bus.rght_pdm_in = 1'b0;
    bus.Flt_n       = 1'b1;
    model_reset();
    repeat (3) @(negedge clk);
    chk("reset_vals", dut_vec(), 9'b1_0000_000_0);
    rst_n = 1'b1;

    // power-up with fixed PDM inputs
    bus.lft_pdm_in  = 1'b1;
    bus.rght_pdm_in = 1'b0;
    repeat (10) tick();
    chk("shdn_hold", bus.sht_dwn, 1);
    bus.audio_rdy = 1'b1;
    tick();
    chk("pwrup_sht_fall", bus.sht_dwn, 0);
    chk("idle_first", {bus.lft_PDM, bus.rght_PDM}, 2'b11);
    for (int i = 1; i < PWRUP; i++) begin
      tick();
      chk("idle_toggle", {bus.lft_PDM, bus.rght_PDM}, (i % 2 == 0) ? 2'b11 : 2'b00);
    end
    tick();
    chk("run_first", {bus.lft_PDM, bus.lft_PDM_n, bus.rght_PDM, bus.rght_PDM_n}, 4'b1001);

    // random pass-through, audio_rdy ignored in RUN
    repeat (40) begin
      bus.audio_rdy = 1'($urandom_range(0, 1));
      tick_rand();
    end
    bus.audio_rdy = 1'b1;

    // glitch rejection: directed 1..3 cycles, then random short pulses
    for (int g = 1; g < FILT; g++) begin
      bus.Flt_n = 1'b0;
      repeat (g) tick_rand();
      bus.Flt_n = 1'b1;
      repeat (6) tick_rand();
    end
    repeat (5) begin
      bus.Flt_n = 1'b0;
      repeat ($urandom_range(1, FILT - 1)) tick_rand();
      bus.Flt_n = 1'b1;
      repeat ($urandom_range(3, 8)) tick_rand();
    end
    chk("glitch_cnt", bus.fault_cnt, 0);
    chk("glitch_sht", bus.sht_dwn, 0);

    // fault and retry: Flt_n low sampled on edges 0..49
    bus.Flt_n = 1'b0;
    repeat (5) tick_rand();
    chk("flt_edge4", bus.sht_dwn, 0);
    tick_rand();
    chk("flt_edge5", {bus.sht_dwn, bus.lft_PDM, bus.lft_PDM_n, bus.rght_PDM, bus.rght_PDM_n}, 5'b10000);
    chk("flt_cnt1", bus.fault_cnt, 1);
    repeat (44) tick_rand();
    bus.Flt_n = 1'b1;
    repeat (2) tick_rand();
    chk("retry_hold", bus.sht_dwn, 1);
    tick_rand();
    chk("retry_exit", bus.sht_dwn, 0);
    repeat (PWRUP - 1) tick_rand();
    bus.lft_pdm_in  = 1'($urandom_range(0, 1));
    bus.rght_pdm_in = 1'b1;
    last_l = bus.lft_pdm_in;
    tick();
    chk("rerun_pass", {bus.lft_PDM, bus.rght_PDM_n}, {last_l, 1'b0});
    repeat (10) tick_rand();

    // second fault leads to lockout after exactly RETRY cycles
    bus.Flt_n = 1'b0;
    repeat (6) tick_rand();
    chk("flt_cnt2", bus.fault_cnt, 2);
    repeat (2) tick_rand();
    bus.Flt_n = 1'b1;
    repeat (RETRY - 3) tick_rand();
    chk("lock_early", bus.lockout, 0);
    tick_rand();
    chk("lock_set", bus.lockout, 1);
    repeat (100) tick_rand();
    chk("lock_sht", bus.sht_dwn, 1);
    chk("lock_cnt", bus.fault_cnt, 2);

    // reset from LOCKOUT, then fault coinciding with the last warm-up cycle
    reset_async("rst_lockout");
    tick_rand();
    chk("simul_warm", bus.sht_dwn, 0);
    repeat (10) tick_rand();
    bus.Flt_n = 1'b0;
    repeat (PWRUP - 11) tick_rand();
    chk("simul_pre", bus.sht_dwn, 0);
    tick_rand();
    chk("simul_fault", {bus.sht_dwn, bus.lft_PDM, bus.fault_cnt}, {1'b1, 1'b0, 3'd1});

    // reset while in FAULT
    repeat (10) tick_rand();
    bus.Flt_n = 1'b1;
    reset_async("rst_fault");
    repeat (25) tick_rand();
    chk("post_rst_cnt", bus.fault_cnt, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
